// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream bus select arbiter.
//   FIFO_SEL_BASE   : bus_sel code of FIFO 0 (FIFO i -> FIFO_SEL_BASE + i)
//   NON_FIFO_CHOOSE : bus_sel code when no FIFO owns the bus
//   arb_state_t     : arbiter FSM state
//   fifo_sel_code() : index -> bus_sel code
package axis_arb_pkg;

    localparam int unsigned SEL_W = 8;
    localparam int unsigned IDX_MAX_W = 7;

    localparam logic [SEL_W-1:0] FIFO_SEL_BASE   = 8'd128;
    localparam logic [SEL_W-1:0] NON_FIFO_CHOOSE = 8'd0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [SEL_W-1:0] fifo_sel_code(input logic [IDX_MAX_W-1:0] idx);
        return FIFO_SEL_BASE | SEL_W'(idx);
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from
// ptr+1 upward, wrapping modulo NUM_FIFO (ptr itself is checked last).
//   req    : request vector
//   ptr    : index of the previous winner
//   found  : any request set
//   idx    : winning index
//   onehot : one-hot copy of idx (zero when nothing found)
module axis_rr_pick #(
    parameter int unsigned NUM_FIFO = 4,
    parameter int unsigned IW       = 2
) (
    input  logic [NUM_FIFO-1:0] req,
    input  logic [IW-1:0]       ptr,
    output logic                found,
    output logic [IW-1:0]       idx,
    output logic [NUM_FIFO-1:0] onehot
);

    int unsigned cand;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = 0;
        for (int unsigned k = 1; k <= NUM_FIFO; k++) begin
            cand = (32'(ptr) + k) % NUM_FIFO;
            if (!found && req[IW'(cand)]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
        if (found) begin
            onehot = NUM_FIFO'(1) << idx;
        end
    end

endmodule

// File: rtl/axis_bus_sel_arbiter.sv
// Packet-level round-robin arbiter driving the AXI-Stream demux/mux bus_sel.
// Holds a grant until the granted packet's tlast handshake, then spends one
// IDLE cycle before re-arbitrating.
//   clk, rst_n      : clock, async active-low reset
//   enable          : allow new grants (packet in flight always completes)
//   fifo_req        : per-FIFO packet available
//   beat_valid/ready/last : handshake of the selected stream
//   bus_sel         : 0 idle, 128+i when FIFO i granted
//   grant, busy     : one-hot selection, grant held
//   timeout_evt     : watchdog release pulse
// Optional stall watchdog: define AXIS_ARB_WATCHDOG_EN.
module axis_bus_sel_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_FIFO       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_FIFO-1:0] fifo_req,
    input  logic                beat_valid,
    input  logic                beat_ready,
    input  logic                beat_last,
    output logic [7:0]          bus_sel,
    output logic [NUM_FIFO-1:0] grant,
    output logic                busy,
    output logic                timeout_evt
);

    localparam int unsigned IW = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

    // Elaboration-time parameter sanity checks.
    if (NUM_FIFO < 1 || NUM_FIFO > 127) begin : g_bad_num_fifo
        $error("NUM_FIFO must be 1..127");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [7:0]          bus_sel_q, bus_sel_d;
    logic [NUM_FIFO-1:0] grant_q, grant_d;
    logic                busy_q, busy_d;

    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic [NUM_FIFO-1:0] pick_onehot;
    logic                beat_hs;

    assign beat_hs = beat_valid & beat_ready;

    axis_rr_pick #(
        .NUM_FIFO (NUM_FIFO),
        .IW       (IW)
    ) u_pick (
        .req    (fifo_req),
        .ptr    (ptr_q),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

`ifdef AXIS_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_evt_q, timeout_evt_d;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        bus_sel_d = bus_sel_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
`ifdef AXIS_ARB_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_evt_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                bus_sel_d = NON_FIFO_CHOOSE;
                grant_d   = '0;
                busy_d    = 1'b0;
`ifdef AXIS_ARB_WATCHDOG_EN
                wd_cnt_d  = '0;
`endif
                if (enable && pick_found) begin
                    state_d   = GRANT;
                    ptr_d     = pick_idx;
                    bus_sel_d = fifo_sel_code(IDX_MAX_W'(pick_idx));
                    grant_d   = pick_onehot;
                    busy_d    = 1'b1;
                end
            end
            GRANT: begin
                if (beat_hs && beat_last) begin
                    state_d   = IDLE;
                    bus_sel_d = NON_FIFO_CHOOSE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
`ifdef AXIS_ARB_WATCHDOG_EN
                    wd_cnt_d  = '0;
                end else if (beat_hs) begin
                    wd_cnt_d  = '0;
                end else if (wd_cnt_q == WD_LIMIT) begin
                    // Stalled too long: drop the grant; ptr keeps this index.
                    state_d       = IDLE;
                    bus_sel_d     = NON_FIFO_CHOOSE;
                    grant_d       = '0;
                    busy_d        = 1'b0;
                    wd_cnt_d      = '0;
                    timeout_evt_d = 1'b1;
                end else begin
                    wd_cnt_d  = wd_cnt_q + WD_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NUM_FIFO - 1);
            bus_sel_q <= NON_FIFO_CHOOSE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            bus_sel_q <= bus_sel_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

`ifdef AXIS_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign timeout_evt = timeout_evt_q;
`else
    assign timeout_evt = 1'b0;
`endif

    assign bus_sel = bus_sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_axis_bus_sel_arbiter.sv
// Directed bench for axis_bus_sel_arbiter (NUM_FIFO=4, TIMEOUT_CYCLES=8).
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_axis_bus_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] fifo_req;
    logic       beat_valid;
    logic       beat_ready;
    logic       beat_last;
    logic [7:0] bus_sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout_evt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    axis_bus_sel_arbiter #(
        .NUM_FIFO       (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo_req    (fifo_req),
        .beat_valid  (beat_valid),
        .beat_ready  (beat_ready),
        .beat_last   (beat_last),
        .bus_sel     (bus_sel),
        .grant       (grant),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sel(input string tag, input logic [7:0] sel);
        check({tag, ".bus_sel"}, 32'(bus_sel), 32'(sel));
        check({tag, ".grant"}, 32'(grant), (sel == 8'd0) ? 32'd0 : (32'd1 << sel[1:0]));
        check({tag, ".busy"}, 32'(busy), (sel == 8'd0) ? 32'd0 : 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        fifo_req   = 4'b0000;
        beat_valid = 1'b0;
        beat_ready = 1'b1;
        beat_last  = 1'b0;
        step();
        step();
        check_sel("reset", 8'd0);
        check("reset.timeout_evt", 32'(timeout_evt), 32'd0);
        rst_n = 1'b1;
        step();
        check_sel("post_reset_idle", 8'd0);

        // Single request, 3-beat packet.
        fifo_req = 4'b0100;
        step();
        check_sel("req2.grant", 8'd130);
        fifo_req   = 4'b0000;
        beat_valid = 1'b1;
        step();
        check_sel("req2.beat1", 8'd130);
        step();
        check_sel("req2.beat2", 8'd130);
        beat_last = 1'b1;
        step();
        check_sel("req2.release", 8'd0);
        beat_valid = 1'b0;
        beat_last  = 1'b0;

        // All requesting, 1-beat packets: ptr=2 so rotation starts at FIFO 3.
        fifo_req   = 4'b1111;
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_sel($sformatf("rr%0d", i),
                      (i % 2 == 0) ? 8'(128 + ((3 + i / 2) % 4)) : 8'd0);
        end
        fifo_req   = 4'b0000;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        step();
        check_sel("rr.idle", 8'd0);

        // Last beat stalled by ready low; requester drops mid-packet (ptr=2 -> FIFO 1).
        fifo_req = 4'b0010;
        step();
        check_sel("stall.grant", 8'd129);
        fifo_req   = 4'b0000;
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        beat_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_sel($sformatf("stall.hold%0d", i), 8'd129);
        end
        beat_ready = 1'b1;
        step();
        check_sel("stall.release", 8'd0);
        beat_valid = 1'b0;
        beat_last  = 1'b0;

        // Enable gating (ptr=1).
        enable   = 1'b0;
        fifo_req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            step();
            check_sel($sformatf("dis%0d", i), 8'd0);
        end
        enable = 1'b1;
        step();
        check_sel("en.grant", 8'd128);
        enable     = 1'b0;
        beat_valid = 1'b1;
        step();
        check_sel("en_drop.hold", 8'd128);
        beat_last = 1'b1;
        step();
        check_sel("en_drop.release", 8'd0);
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_sel($sformatf("en_drop.noregrant%0d", i), 8'd0);
        end

        // Async reset mid-packet (ptr=0 -> FIFO 1).
        enable = 1'b1;
        step();
        check_sel("rst.grant", 8'd129);
        fifo_req = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check_sel("rst.async_clear", 8'd0);
        step();
        rst_n    = 1'b1;
        fifo_req = 4'b0011;
        step();
        check_sel("rst.fifo0_first", 8'd128);
        fifo_req   = 4'b0000;
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        step();
        check_sel("rst.release", 8'd0);
        beat_valid = 1'b0;
        beat_last  = 1'b0;

        // Stalled packet on FIFO 2 (ptr=0).
        fifo_req = 4'b0100;
        step();
        check_sel("wd.grant", 8'd130);
        fifo_req = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            step();
            check_sel($sformatf("wd.stall%0d", i), 8'd130);
            check("wd.no_evt", 32'(timeout_evt), 32'd0);
        end
`ifdef AXIS_ARB_WATCHDOG_EN
        step();
        check_sel("wd.forced_release", 8'd0);
        check("wd.evt", 32'(timeout_evt), 32'd1);
        step();
        check("wd.evt_one_shot", 32'(timeout_evt), 32'd0);
        check_sel("wd.next_fifo0", 8'd128);
`else
        for (int i = 0; i < 5; i++) begin
            step();
            check_sel($sformatf("nowd.hold%0d", i), 8'd130);
            check("nowd.evt", 32'(timeout_evt), 32'd0);
        end
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        fifo_req   = 4'b0000;
        step();
        check_sel("nowd.release", 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_bus_sel_arbiter.md
# axis_bus_sel_arbiter

Packet-level round-robin arbiter that drives the 8-bit `bus_sel` code of the AXI-Stream bus demux/mux pair, sharing one downstream stream among up to `NUM_FIFO` source FIFOs. It picks one requesting FIFO, holds the selection until that FIFO's packet completes (`tlast` handshake), then releases the bus and re-arbitrates. It sits between the FIFO status flags and the bus select logic, one per shared stream.

## Interface
- `NUM_FIFO`, 4: number of requesters, 1..127.
- `TIMEOUT_CYCLES`, 1024: stall watchdog limit. Only used with the watchdog macro; must be ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, no new grant is issued; a packet in flight still completes.
- `fifo_req` in NUM_FIFO: per-FIFO "packet available" (tvalid / non-empty).
- `beat_valid` in 1: tvalid of the selected stream.
- `beat_ready` in 1: tready from downstream (`axis_in_tready`).
- `beat_last` in 1: tlast of the selected stream.
- `bus_sel` out 8: 8'd0 = no FIFO chosen; 8'd128+i = FIFO i chosen.
- `grant` out NUM_FIFO: one-hot copy of the selection; all zero when idle.
- `busy` out 1: high while a grant is held.
- `timeout_evt` out 1: one-cycle pulse when the watchdog forces release. Tied 0 without the macro.

## Operation
- The FSM has two states: IDLE and GRANT.
- IDLE:
  - `bus_sel`=0, `grant`=0, `busy`=0.
  - If `enable` is high and `fifo_req` is nonzero, the arbiter registers the winner and moves to GRANT.
- Round-robin selection:
  - The search starts at `ptr+1` and wraps modulo NUM_FIFO. The first set bit of `fifo_req` wins.
  - `ptr` is updated to the winner on grant.
  - `ptr` resets to NUM_FIFO-1, so FIFO 0 has first priority after reset.
- GRANT:
  - `bus_sel`=128+idx, `grant`=1<<idx, `busy`=1.
  - Leave to IDLE on the edge where `beat_valid & beat_ready & beat_last`.
  - `fifo_req` is ignored while in GRANT. Deassertion of the granted FIFO's request does not release the bus.
- There is always at least one IDLE cycle between packets, during which the demux is in its default (all tready low). This is a dead cycle by design.
- Reset values: `bus_sel`=8'd0, `grant`=0, `busy`=0, `timeout_evt`=0, state IDLE, `ptr`=NUM_FIFO-1, watchdog counter 0.
- Reset asserted mid-packet: all outputs clear immediately (asynchronously). No packet state is retained.
- Simultaneous events: the last beat and new requests in the same cycle produce exit to IDLE only. The new grant is evaluated on the next edge.

## Timing
- Request to select: `fifo_req` sampled high in IDLE at edge k gives `bus_sel`/`grant` valid from edge k (registered outputs, visible in cycle k+1).
- Last beat accepted at edge m: `bus_sel`=0 during cycle m+1. The earliest next grant is visible in cycle m+2.
- Maximum sustained rate: one packet per (packet beats + 1) cycles.
- No combinational path exists from inputs to outputs.

## Configuration
- `AXIS_ARB_WATCHDOG_EN` defined:
  - In GRANT, a counter increments on each cycle without a `beat_valid & beat_ready` handshake and clears on every handshake.
  - When it reaches TIMEOUT_CYCLES-1, the next edge forces IDLE, pulses `timeout_evt` for one cycle, and clears the counter.
  - `ptr` keeps the timed-out index, so that FIFO gets lowest priority next.
- Undefined: no counter exists, `timeout_evt` is constant 0, and a stalled packet holds the bus indefinitely.

## Structure
- Package `axis_arb_pkg` holds:
  - `FIFO_SEL_BASE`=8'd128 and `NON_FIFO_CHOOSE`=8'd0.
  - The state enum (IDLE, GRANT).
  - A function mapping an index to its `bus_sel` code.
- Sub-module `axis_rr_pick`: combinational round-robin priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `idx`, one-hot.
  - Instantiated once.

## Test plan
- Reset, then `fifo_req`=4'b0100: `bus_sel`=8'd130 one cycle later, `grant`=4'b0100, `busy`=1. A 3-beat packet with `beat_last` on beat 3 gives `bus_sel`=0 the following cycle.
- `fifo_req`=4'b1111 held, 1-beat packets: grant sequence is 128,129,130,131,128…, with exactly one `bus_sel`=0 cycle between each grant.
- `beat_ready` low on the last beat for 5 cycles: the grant holds, and release happens only after the ready-high last handshake. A `fifo_req` drop of the granted FIFO mid-packet has no effect.
- `enable`=0 with `fifo_req`=4'b0011: `bus_sel` stays 0. Dropping `enable` mid-packet still lets that packet complete, and no regrant follows.
- `rst_n` asserted mid-packet at `bus_sel`=8'd129: `bus_sel`, `grant` and `busy` clear without waiting for a clock edge. After release, FIFO 0 wins first.
- With `AXIS_ARB_WATCHDOG_EN` and TIMEOUT_CYCLES=8, grant FIFO 2 then give no handshakes: `timeout_evt` pulses once after 8 stalled cycles, `bus_sel`=0, and with `fifo_req`=4'b0101 the next grant is FIFO 0.
